// File: rtl/regfile_param.sv
// Parameterised register file: two combinational read ports, one write port,
// sequenced bulk clear. Define REGFILE_WRITE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_param #(
  parameter int WIDTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [WIDTH-1:0]  rd_data1,
  output logic [WIDTH-1:0]  rd_data2,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_done
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              clr_done_q, clr_done_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic              wr_ok;

  assign busy     = (state_q == CLEAR);
  assign clr_done = clr_done_q;

  // Writes to the hardwired zero register are discarded here, which also
  // keeps them out of the bypass path.
  assign wr_ok = wr_en && !busy && !((ZERO_REG != 0) && (wr_addr == '0));

  // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    clr_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end
      end
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d    = IDLE;
          clr_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      clr_cnt_q  <= '0;
      clr_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      clr_done_q <= clr_done_d;
    end
  end

  // NOTE: the storage array is reset on purpose: reset must clear every entry
  // asynchronously, so it is built from flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (busy) begin
      mem_q[clr_cnt_q] <= '0;
    end else if (wr_ok) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  function automatic logic [WIDTH-1:0] rd_mux(input logic [ADDR_W-1:0] addr);
    logic [WIDTH-1:0] val;
    val = mem_q[addr];
`ifdef REGFILE_WRITE_BYPASS_EN
    if (wr_ok && (addr == wr_addr)) val = wr_data;
`endif
    if ((ZERO_REG != 0) && (addr == '0)) val = '0;
    return val;
  endfunction

  always_comb begin
    rd_data1 = rd_mux(rd_addr1);
    rd_data2 = rd_mux(rd_addr2);
  end

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: default 16x16 instance plus a 32x32 instance.
module tb_regfile_param;

`ifdef REGFILE_WRITE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;

  logic        wr_en, clr_req, busy, clr_done;
  logic [3:0]  wr_addr, rd_addr1, rd_addr2;
  logic [15:0] wr_data, rd_data1, rd_data2;

  logic        wr_en_w, clr_req_w, busy_w, clr_done_w;
  logic [4:0]  wr_addr_w, rd_addr1_w, rd_addr2_w;
  logic [31:0] wr_data_w, rd_data1_w, rd_data2_w;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  regfile_param u_dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(rd_data1), .rd_data2(rd_data2),
    .clr_req(clr_req), .busy(busy), .clr_done(clr_done)
  );

  regfile_param #(.WIDTH(32), .ADDR_W(5), .ZERO_REG(1)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en_w), .wr_addr(wr_addr_w), .wr_data(wr_data_w),
    .rd_addr1(rd_addr1_w), .rd_addr2(rd_addr2_w), .rd_data1(rd_data1_w), .rd_data2(rd_data2_w),
    .clr_req(clr_req_w), .busy(busy_w), .clr_done(clr_done_w)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cycles;
    int pulses;

    rst_n = 1'b1;
    {wr_en, clr_req, wr_addr, wr_data, rd_addr1, rd_addr2} = '0;
    {wr_en_w, clr_req_w, wr_addr_w, wr_data_w, rd_addr1_w, rd_addr2_w} = '0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_clr_done", clr_done, 0);
    rd_addr1 = 4'd5; rd_addr2 = 4'd15;
    #1;
    check("rst_rd1", rd_data1, 0);
    check("rst_rd2", rd_data2, 0);
    check("rst_busy32", busy_w, 0);
    #9 rst_n = 1'b1;

    // Write BEEF to reg 5 on the first edge after reset.
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'hBEEF;
    rd_addr1 = 4'd5; rd_addr2 = 4'd5;
    #1;
    check("wr5_same_cycle", rd_data1, BYP ? 32'hBEEF : 32'h0);
    tick();
    wr_en = 1'b0;
    #1;
    check("wr5_rd1", rd_data1, 32'hBEEF);
    check("wr5_rd2", rd_data2, 32'hBEEF);

    // Same-cycle read of address being written.
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'h1234; rd_addr1 = 4'd3; rd_addr2 = 4'd5;
    #1;
    check("byp3_rd1", rd_data1, BYP ? 32'h1234 : 32'h0);
    check("byp3_rd2_other", rd_data2, 32'hBEEF);
    tick();
    wr_en = 1'b0;
    #1;
    check("wr3_after", rd_data1, 32'h1234);

    // Register 0 is hardwired to zero, bypass included.
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'hFFFF; rd_addr1 = 4'd0; rd_addr2 = 4'd0;
    #1;
    check("zero_same_rd1", rd_data1, 0);
    check("zero_same_rd2", rd_data2, 0);
    tick();
    wr_en = 1'b0;
    #1;
    check("zero_next", rd_data1, 0);

    // Fill 1..15 with A00i, then run a full clear.
    for (int i = 1; i < 16; i++) begin
      wr_en = 1'b1; wr_addr = 4'(i); wr_data = 16'hA000 | 16'(i);
      tick();
    end
    wr_en = 1'b0;
    rd_addr1 = 4'd15; rd_addr2 = 4'd7;
    #1;
    check("fill_r15", rd_data1, 32'hA00F);
    check("fill_r7", rd_data2, 32'hA007);

    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    cycles = 0;
    pulses = 0;
    while (busy && cycles < 64) begin
      wr_en = (cycles == 0);
      wr_addr = 4'd7; wr_data = 16'h7777;
      clr_req = (cycles == 3);
      #1;
      if (clr_done) pulses++;
      if (cycles == 0) begin
        check("busy_uncleared_r15", rd_data1, 32'hA00F);
        check("busy_no_bypass_r7", rd_data2, 32'hA007);
      end
      tick();
      cycles++;
    end
    wr_en = 1'b0; clr_req = 1'b0;
    check("clear_busy_cycles", cycles, 16);
    check("clear_done_pulse", clr_done, 1);
    check("clear_done_not_during_busy", pulses, 0);
    tick();
    check("clear_done_one_cycle", clr_done, 0);
    check("clear_idle_after", busy, 0);
    for (int i = 0; i < 16; i++) begin
      rd_addr1 = 4'(i); rd_addr2 = 4'(15 - i);
      #1;
      check($sformatf("clr_rd1_r%0d", i), rd_data1, 0);
    end
    rd_addr2 = 4'd7;
    #1;
    check("clr_dropped_wr_r7", rd_data2, 0);

    // Abort a clear with reset when clr_cnt reaches 8.
    wr_en = 1'b1; wr_addr = 4'd9; wr_data = 16'h5555;
    tick();
    wr_addr = 4'd2; wr_data = 16'h2222;
    tick();
    wr_en = 1'b0;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    rd_addr1 = 4'd9; rd_addr2 = 4'd2;
    #1;
    check("abort_busy_before", busy, 1);
    check("abort_r9_kept", rd_data1, 32'h5555);
    check("abort_r2_cleared", rd_data2, 0);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_r9_zero", rd_data1, 0);
    check("abort_done", clr_done, 0);
    tick();
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (clr_done || busy) pulses++;
    end
    check("abort_no_done", pulses, 0);

    // Wide instance: reg 31 write/readback and a 32-cycle clear.
    wr_en_w = 1'b1; wr_addr_w = 5'd31; wr_data_w = 32'hDEADBEEF;
    tick();
    wr_en_w = 1'b0; rd_addr1_w = 5'd31; rd_addr2_w = 5'd31;
    #1;
    check("w32_r31_rd1", rd_data1_w, 32'hDEADBEEF);
    check("w32_r31_rd2", rd_data2_w, 32'hDEADBEEF);
    clr_req_w = 1'b1;
    tick();
    clr_req_w = 1'b0;
    cycles = 0;
    while (busy_w && cycles < 100) begin
      tick();
      cycles++;
    end
    check("w32_busy_cycles", cycles, 32);
    check("w32_done", clr_done_w, 1);
    check("w32_r31_cleared", rd_data1_w, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
